loop_sequencer: RTL and testbench
=================================

Name: loop_sequencer

Overview:
Round-loop sequencer for the hash core. It sits directly upstream of the loop-limit checker and drives its `current_loop` and `stop` inputs. It consumes the checker's `fail` and `current_loop_actualize` outputs as feedback. It issues one round request at a time to the round engine, counts completed rounds against a latched target, and halts cleanly on completion, on a checker fail, or on an external abort.

Parameters:
WIDTH, 16, width of the loop counter, the target and the actualize bus
MAX_ROUNDS, 8000, upper clamp applied to the requested round count when it is latched

Ports:
clk  input  1  system clock; all logic is rising-edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a loop run; honoured only in IDLE
rounds  input  WIDTH  requested round count; sampled with start
abort  input  1  synchronous request to terminate the current run
step  input  1  one-cycle pulse from the round engine; the current round has completed
fail  input  1  loop-limit checker fault flag
current_loop_actualize  input  WIDTH  corrected loop value from the checker; loaded on fail
current_loop  output  WIDTH  completed-round count; feeds the checker
stop  output  1  high while no run is active; feeds the checker
round_req  output  1  one-cycle pulse that requests the next round
busy  output  1  high in ISSUE and WAIT
done  output  1  one-cycle pulse on normal completion
aborted  output  1  sticky; set on fail or abort; cleared by the next accepted start

Behaviour:
- Reset (reset=0, asynchronous) puts the block in IDLE with current_loop=0, stop=1, round_req=0, busy=0, done=0, aborted=0. The latched target is cleared to 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT. busy=1 exactly in ISSUE and WAIT.
- IDLE:
  - start with rounds==0: done pulses the next cycle, the block stays in IDLE, current_loop is unchanged and aborted is cleared.
  - start with rounds!=0:
    - target <= min(rounds, MAX_ROUNDS)
    - current_loop <= 0, stop <= 0, aborted <= 0
    - go to ISSUE
  - step, fail and abort are ignored in IDLE.
- ISSUE: round_req=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - step: next = current_loop+1.
    - If next==target: current_loop <= next, stop <= 1, done pulses one cycle, go to IDLE.
    - Otherwise: current_loop <= next, go to ISSUE.
  - No step: hold.
- Latency: the first round_req appears 1 cycle after start is sampled. A step-to-next-round_req turnaround takes 1 cycle.
- Fault/abort (evaluated in ISSUE or WAIT):
  - fail=1: current_loop <= current_loop_actualize, stop <= 1, aborted <= 1, go to IDLE.
  - abort=1 with fail=0: current_loop is held, stop <= 1, aborted <= 1, go to IDLE.
  - No done pulse is produced in either case.
  - If fail occurs during ISSUE, round_req still pulses that cycle. A round_req already issued is not retracted.
- Priority within one cycle: fail > abort > step.
  - fail and step together: the actualize value is loaded and no increment occurs.
- start while busy is ignored, and the latched target is not changed.
- rounds is sampled only on an accepted start. Later changes to rounds have no effect on a run in progress.
- Width rules:
  - The counter never exceeds target, so no wrap occurs.
  - MAX_ROUNDS must be ≤ 2^WIDTH−1.
  - current_loop_actualize is loaded verbatim, even if it exceeds target.
  - A subsequent run restarts the count from 0.
- stop stays high from reset until the first accepted start.

Test Plan:
1. Release reset; pulse start with rounds=3 and answer every round_req with step 2 cycles later -> round_req pulses 3 times, current_loop steps 0→1→2→3, done pulses once, stop rises in the same cycle as current_loop=3, busy falls.
2. start with rounds=9000 (MAX_ROUNDS=8000) -> target latched as 8000; after 8000 steps, done pulses and current_loop=8000; a shortened check uses MAX_ROUNDS=5 and rounds=120 -> 5 rounds.
3. Run rounds=10; at current_loop=4, assert fail with current_loop_actualize=456 together with step -> current_loop=456, no increment, stop=1, aborted=1, no done, state IDLE.
4. Run rounds=10; assert abort at current_loop=2 -> current_loop holds 2, stop=1, aborted=1; a following start with rounds=2 clears aborted and restarts the count from 0.
5. Pulse start again mid-run with rounds=50 -> ignored; the original target completes. In a separate run, start with rounds=0 -> a single done pulse, stop stays 1, no round_req.
6. Assert reset low during WAIT at current_loop=7 -> outputs immediately return to reset values (current_loop=0, stop=1, busy=0, aborted=0) without waiting for a clock edge.

Source files
------------

// File: rtl/loop_sequencer_if.sv
// Handshake bundle between the round-loop sequencer, its controller,
// the round engine and the loop-limit checker.
interface loop_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] rounds;
    logic             abort;
    logic             step;
    logic             fail;
    logic [WIDTH-1:0] current_loop_actualize;
    logic [WIDTH-1:0] current_loop;
    logic             stop;
    logic             round_req;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
        output start, rounds, abort, step, fail, current_loop_actualize,
        input  current_loop, stop, round_req, busy, done, aborted
    );

    modport slave (
        input  start, rounds, abort, step, fail, current_loop_actualize,
        output current_loop, stop, round_req, busy, done, aborted
    );
endinterface

// File: rtl/loop_sequencer.sv
// Round-loop sequencer: issues one round request at a time, counts
// completed rounds against a clamped target, and halts on completion,
// checker fail or external abort. All outputs are registered.
module loop_sequencer #(
    parameter int WIDTH      = 16,
    parameter int MAX_ROUNDS = 8000
) (
    input  logic             clk,
    input  logic             reset,
    loop_sequencer_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] next_loop;

    // Candidate count after the current round completes.
    always_comb begin
        next_loop = bus.current_loop + WIDTH'(1);
    end

    // Sequencer FSM with all outputs registered; fail beats abort beats step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            target           <= '0;
            bus.current_loop <= '0;
            bus.stop         <= 1'b1;
            bus.round_req    <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.aborted      <= 1'b0;
        end else begin
            bus.round_req <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.aborted <= 1'b0;
                        if (bus.rounds == '0) begin
                            bus.done <= 1'b1;
                        end else begin
                            target           <= (bus.rounds > MAX_W) ? MAX_W : bus.rounds;
                            bus.current_loop <= '0;
                            bus.stop         <= 1'b0;
                            bus.busy         <= 1'b1;
                            bus.round_req    <= 1'b1;
                            state            <= ISSUE;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    if (bus.fail) begin
                        bus.current_loop <= bus.current_loop_actualize;
                        bus.stop         <= 1'b1;
                        bus.aborted      <= 1'b1;
                        bus.busy         <= 1'b0;
                        state            <= IDLE;
                    end else if (bus.abort) begin
                        bus.stop    <= 1'b1;
                        bus.aborted <= 1'b1;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                    end else if (state == ISSUE) begin
                        state <= WAIT;
                    end else if (bus.step) begin
                        bus.current_loop <= next_loop;
                        if (next_loop == target) begin
                            bus.stop <= 1'b1;
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            bus.round_req <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_loop_sequencer.sv
// Directed self-checking bench for loop_sequencer (WIDTH=16, MAX_ROUNDS=8000).
module tb_loop_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    loop_sequencer_if #(.WIDTH(16)) bus ();

    loop_sequencer #(.WIDTH(16), .MAX_ROUNDS(8000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Answers each round_req with a step two cycles later until busy falls.
    task automatic serve(input int budget, output int reqs, output int dones, output bit finished);
        reqs = 0;
        dones = 0;
        finished = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (bus.done) dones++;
            if (!bus.busy) begin
                finished = 1'b1;
                break;
            end
            if (bus.round_req) begin
                reqs++;
                tick();
                bus.step = 1'b1;
            end
            tick();
            bus.step = 1'b0;
        end
    endtask

    task automatic do_rounds(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.step = 1'b1;
            tick();
            bus.step = 1'b0;
        end
    endtask

    task automatic begin_run(input logic [15:0] r);
        bus.rounds = r;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++; if (bus.current_loop !== 16'd0) begin bad++; $display("FAIL rst_loop got=%0d exp=0", bus.current_loop); end
        total++; if ({bus.stop, bus.round_req, bus.busy, bus.done, bus.aborted} !== 5'b10000) begin bad++; $display("FAIL rst_flags got=%b exp=10000", {bus.stop, bus.round_req, bus.busy, bus.done, bus.aborted}); end
        reset = 1'b1;
        tick();
        total++; if ({bus.stop, bus.busy, bus.current_loop} !== {1'b1, 1'b0, 16'd0}) begin bad++; $display("FAIL rst_release stop=%b busy=%b loop=%0d exp 1 0 0", bus.stop, bus.busy, bus.current_loop); end
    endtask

    task automatic test_basic_run();
        begin_run(16'd3);
        total++; if ({bus.round_req, bus.busy, bus.stop} !== 3'b110) begin bad++; $display("FAIL t1_first_req got=%b exp=110", {bus.round_req, bus.busy, bus.stop}); end
        total++; if (bus.current_loop !== 16'd0) begin bad++; $display("FAIL t1_loop0 got=%0d exp=0", bus.current_loop); end
        for (int r = 1; r <= 3; r++) begin
            tick();
            total++; if (bus.round_req !== 1'b0) begin bad++; $display("FAIL t1_req_width r=%0d got=%b exp=0", r, bus.round_req); end
            bus.step = 1'b1;
            tick();
            bus.step = 1'b0;
            total++; if (bus.current_loop !== 16'(r)) begin bad++; $display("FAIL t1_count got=%0d exp=%0d", bus.current_loop, r); end
            if (r < 3) begin
                total++; if ({bus.round_req, bus.done, bus.stop, bus.busy} !== 4'b1001) begin bad++; $display("FAIL t1_mid r=%0d got=%b exp=1001", r, {bus.round_req, bus.done, bus.stop, bus.busy}); end
            end else begin
                total++; if ({bus.round_req, bus.done, bus.stop, bus.busy} !== 4'b0110) begin bad++; $display("FAIL t1_end got=%b exp=0110", {bus.round_req, bus.done, bus.stop, bus.busy}); end
            end
        end
        tick();
        total++; if ({bus.done, bus.round_req, bus.current_loop} !== {2'b00, 16'd3}) begin bad++; $display("FAIL t1_after done=%b req=%b loop=%0d exp 0 0 3", bus.done, bus.round_req, bus.current_loop); end
    endtask

    task automatic test_clamp();
        int  reqs, dones;
        bit  fin;
        begin_run(16'd9000);
        serve(20000, reqs, dones, fin);
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL t2_timeout got=%0d exp=1", fin); end
        total++; if (reqs !== 8000) begin bad++; $display("FAIL t2_reqs got=%0d exp=8000", reqs); end
        total++; if (dones !== 1) begin bad++; $display("FAIL t2_dones got=%0d exp=1", dones); end
        total++; if (bus.current_loop !== 16'd8000) begin bad++; $display("FAIL t2_loop got=%0d exp=8000", bus.current_loop); end
        tick();
    endtask

    task automatic test_fail();
        begin_run(16'd10);
        do_rounds(4);
        tick();
        bus.fail = 1'b1;
        bus.current_loop_actualize = 16'd456;
        bus.step = 1'b1;
        tick();
        bus.fail = 1'b0;
        bus.step = 1'b0;
        total++; if (bus.current_loop !== 16'd456) begin bad++; $display("FAIL t3_actualize got=%0d exp=456", bus.current_loop); end
        total++; if ({bus.stop, bus.aborted, bus.busy, bus.done} !== 4'b1100) begin bad++; $display("FAIL t3_flags got=%b exp=1100", {bus.stop, bus.aborted, bus.busy, bus.done}); end
        tick();
        total++; if ({bus.done, bus.round_req, bus.busy, bus.current_loop} !== {3'b000, 16'd456}) begin bad++; $display("FAIL t3_idle done=%b req=%b busy=%b loop=%0d exp 0 0 0 456", bus.done, bus.round_req, bus.busy, bus.current_loop); end
    endtask

    task automatic test_abort();
        int  reqs, dones;
        bit  fin;
        begin_run(16'd10);
        do_rounds(2);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++; if (bus.current_loop !== 16'd2) begin bad++; $display("FAIL t4_hold got=%0d exp=2", bus.current_loop); end
        total++; if ({bus.stop, bus.aborted, bus.busy, bus.done} !== 4'b1100) begin bad++; $display("FAIL t4_flags got=%b exp=1100", {bus.stop, bus.aborted, bus.busy, bus.done}); end
        bus.step = 1'b1;
        bus.fail = 1'b1;
        bus.current_loop_actualize = 16'd77;
        tick();
        bus.step = 1'b0;
        bus.fail = 1'b0;
        total++; if ({bus.current_loop, bus.busy} !== {16'd2, 1'b0}) begin bad++; $display("FAIL t4_idle_ignore loop=%0d busy=%b exp 2 0", bus.current_loop, bus.busy); end
        begin_run(16'd2);
        total++; if ({bus.aborted, bus.busy, bus.current_loop} !== {2'b01, 16'd0}) begin bad++; $display("FAIL t4_restart aborted=%b busy=%b loop=%0d exp 0 1 0", bus.aborted, bus.busy, bus.current_loop); end
        serve(100, reqs, dones, fin);
        total++; if ({fin, reqs, dones} !== {1'b1, 32'd2, 32'd1}) begin bad++; $display("FAIL t4_rerun fin=%0d reqs=%0d dones=%0d exp 1 2 1", fin, reqs, dones); end
        total++; if (bus.current_loop !== 16'd2) begin bad++; $display("FAIL t4_rerun_loop got=%0d exp=2", bus.current_loop); end
        tick();
    endtask

    task automatic test_start_ignored();
        int  reqs, dones;
        bit  fin;
        begin_run(16'd5);
        do_rounds(1);
        begin_run(16'd50);
        total++; if ({bus.busy, bus.current_loop, bus.round_req} !== {1'b1, 16'd1, 1'b0}) begin bad++; $display("FAIL t5_midstart busy=%b loop=%0d req=%b exp 1 1 0", bus.busy, bus.current_loop, bus.round_req); end
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        serve(200, reqs, dones, fin);
        total++; if ({fin, reqs, dones} !== {1'b1, 32'd3, 32'd1}) begin bad++; $display("FAIL t5_target fin=%0d reqs=%0d dones=%0d exp 1 3 1", fin, reqs, dones); end
        total++; if (bus.current_loop !== 16'd5) begin bad++; $display("FAIL t5_loop got=%0d exp=5", bus.current_loop); end
        tick();
        begin_run(16'd0);
        total++; if ({bus.done, bus.stop, bus.round_req, bus.busy} !== 4'b1100) begin bad++; $display("FAIL t5_zero got=%b exp=1100", {bus.done, bus.stop, bus.round_req, bus.busy}); end
        total++; if (bus.current_loop !== 16'd5) begin bad++; $display("FAIL t5_zero_loop got=%0d exp=5", bus.current_loop); end
        tick();
        total++; if ({bus.done, bus.round_req, bus.busy} !== 3'b000) begin bad++; $display("FAIL t5_zero_after got=%b exp=000", {bus.done, bus.round_req, bus.busy}); end
    endtask

    task automatic test_async_reset();
        begin_run(16'd20);
        do_rounds(7);
        tick();
        total++; if ({bus.current_loop, bus.busy} !== {16'd7, 1'b1}) begin bad++; $display("FAIL t6_pre loop=%0d busy=%b exp 7 1", bus.current_loop, bus.busy); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus.current_loop !== 16'd0) begin bad++; $display("FAIL t6_loop got=%0d exp=0", bus.current_loop); end
        total++; if ({bus.stop, bus.busy, bus.aborted, bus.round_req, bus.done} !== 5'b10000) begin bad++; $display("FAIL t6_flags got=%b exp=10000", {bus.stop, bus.busy, bus.aborted, bus.round_req, bus.done}); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.rounds = '0;
        bus.abort = 1'b0;
        bus.step = 1'b0;
        bus.fail = 1'b0;
        bus.current_loop_actualize = '0;
        test_reset();
        test_basic_run();
        test_clamp();
        test_fail();
        test_abort();
        test_start_ignored();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
